uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx transmitter between four requesters. A round-robin
// arbiter picks a requester in IDLE, latches its byte, fires a one-cycle
// tx_start, then waits in WAIT for the transmitter's tx_done before reporting
// completion to the winner through a one-cycle done pulse.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to add a WAIT watchdog. When
// the watchdog counts TIMEOUT_CYCLES clocks in WAIT without tx_done, the
// block pulses timeout and returns to IDLE without a done pulse. Without the
// macro no counter exists, timeout is tied low and WAIT waits indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  clocks allowed in WAIT before abort (watchdog build only)
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   req        in   4   per-requester transmit request
//   req_data   in  32   requester i byte at [8i+7:8i]
//   grant      out  4   one-hot pulse: request accepted, byte latched
//   done       out  4   one-hot pulse: requester byte fully transmitted
//   tx_start   out  1   start pulse to uart_tx
//   tx_data    out  8   byte to uart_tx, held from tx_start until IDLE
//   tx_done    in   1   end-of-frame pulse from uart_tx
//   active_id  out  2   index of current/last granted requester
//   busy       out  1   high whenever not in IDLE
//   timeout    out  1   watchdog abort pulse (0 when compiled out)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [1:0]  active_id,
    output logic        busy,
    output logic        timeout
);

    // The watchdog compares against TIMEOUT_CYCLES-1, so at least 2 is needed.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  done_q, done_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [1:0]  active_id_q, active_id_d;
    logic [1:0]  last_id_q, last_id_d;
    logic        timeout_q, timeout_d;

    logic        win_found;
    logic [1:0]  win_id;
    logic [1:0]  cand;
    logic        tmo_hit;

    // -------------------------------------------------------------------------
    // Round-robin search: start one past the last winner and wrap, so the
    // last winner has the lowest priority on the next pick.
    // -------------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_id    = last_id_q;
        cand      = last_id_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_id_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Cleared in START so the count is zero in the first WAIT cycle; the
    // terminal value TIMEOUT_CYCLES-1 therefore falls on the last WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == START) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register (all outputs are registered alongside the state).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 4'b0000;
            done_q      <= 4'b0000;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            active_id_q <= 2'd0;
            last_id_q   <= 2'd3;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            active_id_q <= active_id_d;
            last_id_q   <= last_id_d;
            timeout_q   <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done || tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered outputs. Pulses default low
    // so each lasts exactly the one cycle after the transition that set it.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_d     = 4'b0000;
        done_d      = 4'b0000;
        tx_start_d  = 1'b0;
        timeout_d   = 1'b0;
        tx_data_d   = tx_data_q;
        active_id_d = active_id_q;
        last_id_d   = last_id_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d     = 4'b0001 << win_id;
                    tx_start_d  = 1'b1;
                    tx_data_d   = req_data[{win_id, 3'b000} +: 8];
                    active_id_d = win_id;
                    last_id_d   = win_id;
                end
            end
            WAIT: begin
                // tx_done has priority over a coincident watchdog expiry.
                if (tx_done) begin
                    done_d = 4'b0001 << active_id_q;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign active_id = active_id_q;
    assign busy      = (state_q != IDLE);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Scoreboard bench for uart_tx_arbiter. Expected grants (requester, byte) and
// expected done pulses are queued when stimulus is driven and retired by the
// per-cycle monitor when the DUT produces them. The watchdog scenario runs
// when UART_ARB_TIMEOUT_EN is defined; otherwise WAIT is checked to hold.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic [1:0]  active_id;
    logic        busy;
    logic        timeout;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .done      (done),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .active_id (active_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } gnt_t;

    gnt_t       gnt_q[$];
    logic [1:0] done_q[$];

    int         n_vec = 0;
    int         n_err = 0;
    logic       exp_timeout = 1'b0;
    logic       saw_grant = 1'b0;
    logic [7:0] cur_data = 8'h00;
    logic [3:0] prev_grant = 4'b0, prev_done = 4'b0;
    logic       prev_start = 1'b0, prev_to = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic onehot0(input logic [3:0] v);
        return (v & (v - 4'd1)) == 4'd0;
    endfunction

    function automatic logic [7:0] byte_of(input logic [1:0] id);
        logic [31:0] d;
        d = req_data;
        return d[{id, 3'b000} +: 8];
    endfunction

    // One clock: sample at the falling edge and retire scoreboard entries.
    task automatic cyc();
        logic viol;
        gnt_t e;
        logic [1:0] did;
        @(negedge clk);
        viol = ((grant & prev_grant) != 4'd0) || ((done & prev_done) != 4'd0) ||
               (tx_start && prev_start) || (timeout && prev_to) ||
               !onehot0(grant) || !onehot0(done);
        chk("pulse_rules", {31'd0, viol}, 32'd0);
        chk("start_eq_grant", {31'd0, tx_start}, {31'd0, |grant});
        chk("timeout", {31'd0, timeout}, {31'd0, exp_timeout});
        saw_grant = 1'b0;
        if (grant != 4'd0) begin
            saw_grant = 1'b1;
            if (gnt_q.size() == 0) begin
                chk("unexp_grant", {28'd0, grant}, 32'd0);
            end else begin
                e = gnt_q.pop_front();
                chk("grant", {28'd0, grant}, 32'd1 << e.id);
                chk("tx_data", {24'd0, tx_data}, {24'd0, e.data});
                chk("active_id", {30'd0, active_id}, {30'd0, e.id});
                chk("busy_start", {31'd0, busy}, 32'd1);
                cur_data = e.data;
            end
        end else if (busy) begin
            chk("tx_data_hold", {24'd0, tx_data}, {24'd0, cur_data});
        end
        if (done != 4'd0) begin
            if (done_q.size() == 0) begin
                chk("unexp_done", {28'd0, done}, 32'd0);
            end else begin
                did = done_q.pop_front();
                chk("done", {28'd0, done}, 32'd1 << did);
            end
        end
        prev_grant = grant;
        prev_done  = done;
        prev_start = tx_start;
        prev_to    = timeout;
    endtask

    // Queue a grant expectation, drive req, and require the grant next cycle.
    task automatic expect_grant(input logic [1:0] id, input logic [3:0] r);
        int n;
        gnt_t e;
        e.id   = id;
        e.data = byte_of(id);
        gnt_q.push_back(e);
        req = r;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!saw_grant && n < 20);
        if (!saw_grant) chk("grant_wait", 32'd0, 32'd1);
        chk("grant_latency", n, 32'd1);
        chk("grant_pending", gnt_q.size(), 32'd0);
    endtask

    // Pulse tx_done once; the done for id must appear the next cycle.
    task automatic finish_tx(input logic [1:0] id);
        done_q.push_back(id);
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        chk("done_pending", done_q.size(), 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tx_done = 1'b0;
        gnt_q.delete();
        done_q.delete();
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_done", {28'd0, done}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_active_id", {30'd0, active_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Spurious tx_done in IDLE: no done, stays idle
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        cyc();
        chk("spurious_idle", {31'd0, busy}, 32'd0);

        // Single request for requester 2
        req_data = 32'h0055_0000;
        expect_grant(2'd2, 4'b0100);
        req = 4'b0000;
        tx_done = 1'b1;               // tx_done during START is ignored
        cyc();
        tx_done = 1'b0;
        chk("wait_busy", {31'd0, busy}, 32'd1);
        req = 4'b1111;                // ignored while busy
        repeat (3) cyc();
        req = 4'b0000;
        cyc();
        finish_tx(2'd2);
        repeat (2) cyc();

        // Contention from reset: order 0,1,2,3,0 with all requests held
        do_reset();
        req_data = 32'h5528_4131;
        for (int k = 0; k < 5; k++) begin
            expect_grant(2'(k), 4'b1111);
            if (k == 4) req = 4'b0000;
            repeat (2) cyc();
            finish_tx(2'(k));
        end
        cyc();

        // Wrap-around: serve 3, then 4'b1001 must pick 0 before 3
        req_data = 32'hA3_00_00_A0;
        expect_grant(2'd3, 4'b1000);
        req = 4'b0000;
        cyc();
        finish_tx(2'd3);
        expect_grant(2'd0, 4'b1001);
        req = 4'b1000;
        cyc();
        finish_tx(2'd0);
        expect_grant(2'd3, 4'b1000);
        req = 4'b0000;
        cyc();
        finish_tx(2'd3);
        cyc();

        // Reset mid-WAIT: no done, priority back to requester 0
        req_data = 32'hD3_C2_B1_A0;
        expect_grant(2'd2, 4'b0100);
        req = 4'b0000;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midwait_busy", {31'd0, busy}, 32'd0);
        chk("midwait_active", {30'd0, active_id}, 32'd0);
        chk("midwait_data", {24'd0, tx_data}, 32'd0);
        expect_grant(2'd1, 4'b1010);
        req = 4'b1000;
        cyc();
        finish_tx(2'd1);
        expect_grant(2'd3, 4'b1000);
        req = 4'b0000;
        cyc();
        finish_tx(2'd3);
        cyc();

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: timeout exactly 16 cycles after WAIT entry, no done
        expect_grant(2'd0, 4'b0001);
        req = 4'b0000;
        repeat (16) cyc();
        exp_timeout = 1'b1;
        cyc();
        exp_timeout = 1'b0;
        chk("timeout_idle", {31'd0, busy}, 32'd0);
        cyc();
        // last_id kept at 0 after the abort, so 1 beats 0
        expect_grant(2'd1, 4'b0011);
        req = 4'b0000;
        cyc();
        finish_tx(2'd1);
        // tx_done on the terminal count wins over the watchdog
        expect_grant(2'd2, 4'b0100);
        req = 4'b0000;
        repeat (16) cyc();
        finish_tx(2'd2);
        repeat (2) cyc();
`else
        // No watchdog: WAIT holds well beyond 16 cycles
        expect_grant(2'd0, 4'b0001);
        req = 4'b0000;
        repeat (40) cyc();
        chk("wait_forever", {31'd0, busy}, 32'd1);
        finish_tx(2'd0);
        repeat (2) cyc();
`endif

        chk("grants_left", gnt_q.size(), 32'd0);
        chk("dones_left", done_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
